pipeline_regfile: RTL and testbench
===================================

Name: pipeline_regfile

Overview:
Parametrised successor to the pipeline register file. It has NUM_RD combinational read ports and one synchronous write port. It adds optional write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard so decode can detect pending writes. It sits between decode (reads, issue) and writeback (write) in the pipelined datapath.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns stored value
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all registers, busy bits and counter
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, combinational
rd_busy  output  NUM_RD  1 = addressed register has an outstanding producer not yet satisfied
wr_en  input  1  writeback enable
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback data
iss_en  input  1  issue of an instruction with a register destination
iss_addr  input  ADDR_W  destination being issued; marked busy
flush  input  1  pipeline flush; clears all busy bits
busy_cnt  output  ADDR_W+1  number of registers currently busy (registered)

Behaviour:
- Reset (async, active-high): all registers = 0, all busy bits = 0, busy_cnt = 0. rd_data reflects zeros immediately. While reset is high, writes and issues are ignored.
- Write: at posedge, if wr_en and not (ZERO_REG and wr_addr==0), then reg[wr_addr] <= wr_data.
- Read port i, combinational, evaluated in priority order:
  - if ZERO_REG and addr==0: returns 0;
  - else if BYPASS and wr_en and wr_addr==addr: returns wr_data;
  - else returns reg[addr].
- Multiple ports may address the same register; each gets the identical value.
- Scoreboard, at posedge:
  - wr_en clears busy[wr_addr];
  - then iss_en sets busy[iss_addr].
  - Issue wins over writeback to the same address in the same cycle: the new producer is outstanding.
  - flush clears all busy bits, then iss_en in the same cycle still sets busy[iss_addr].
  - With ZERO_REG=1, busy[0] is never set.
- rd_busy[i] = busy[addr_i], except:
  - forced 0 when BYPASS and wr_en and wr_addr==addr_i (data is satisfied by the bypass);
  - forced 0 for addr 0 when ZERO_REG=1.
- busy_cnt: registered population count of the busy bits after each update. It never exceeds 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG). Issuing to an already-busy register does not increment it.
- Reset asserted mid-operation: state clears asynchronously. The first write or issue takes effect at the first posedge after reset deasserts.
- Latency: write visible through array storage on the cycle after the edge; through bypass in the same cycle. Busy visible on the cycle after issue.

Test Plan:
- Reset then read: assert reset, write r7=20 during reset -> rd_data for r5, r6, r7 all 0; busy_cnt=0.
- Write/read with bypass: wr_en=1, wr_addr=7, wr_data=20, rd_addr port1=7 in the same cycle -> port1=20 before the edge. Next cycle with wr_en=0 -> port1 still 20. Repeat with BYPASS=0 -> port1=0 before the edge, 20 after.
- Zero register: write r0=0xDEADBEEF, iss_addr=0 -> any port reading r0 returns 0, rd_busy=0, busy_cnt unchanged.
- Scoreboard: issue r4, then r9 -> busy_cnt=2, rd_busy=1 for r4. Writeback r4=32 with port0 on r4 -> rd_busy=0 and rd_data=32 in the same cycle, busy_cnt=1 next cycle.
- Simultaneous events: wr r3 and iss r3 in one cycle -> r3 updated and busy[3]=1 afterwards. flush with iss r8 -> busy_cnt=1, only r8 busy.
- Async reset mid-run: registers r1..r5 written and 3 busy, pulse reset between clock edges -> all outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/pipeline_regfile_if.sv
// Decode/writeback bus of the pipeline register file: read ports,
// writeback port, issue port, flush and the busy counter.
interface pipeline_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/pipeline_regfile.sv
// Pipeline register file: NUM_RD combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired zero register and a
// per-register busy scoreboard with a registered busy counter.
module pipeline_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               reset,
  pipeline_regfile_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              wr_ok;
  logic              byp_ok;
  logic              iss_ok;
  logic [DATA_W-1:0] rd_data_w [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_w;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Register 0 is read-only when hardwired; bypass is suppressed while in
  // reset so the outputs read as zero for the whole reset interval.
  assign wr_ok  = rf.wr_en && !((ZERO_REG != 0) && (rf.wr_addr == '0));
  assign iss_ok = rf.iss_en && !((ZERO_REG != 0) && (rf.iss_addr == '0));
  assign byp_ok = (BYPASS != 0) && rf.wr_en && !reset;

  // Next scoreboard state: flush, then writeback clears, then issue sets
  // (a new producer issued alongside a writeback stays outstanding).
  always_comb begin
    busy_d = busy_q;
    if (rf.flush) busy_d = '0;
    if (rf.wr_en) busy_d[rf.wr_addr] = 1'b0;
    if (iss_ok)   busy_d[rf.iss_addr] = 1'b1;
    busy_cnt_d = popcount(busy_d);
  end

  // Register array storage with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[rf.wr_addr] <= rf.wr_data;
    end
  end

  // Scoreboard bits and their registered population count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    logic              hit;
    assign a       = rf.rd_addr[g*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (a == '0);
    assign hit     = byp_ok && (rf.wr_addr == a);

    // Read port: zero register, then bypass, then stored value.
    always_comb begin
      rd_data_w[g] = regs_q[a];
      rd_busy_w[g] = busy_q[a];
      if (is_zero) begin
        rd_data_w[g] = '0;
        rd_busy_w[g] = 1'b0;
      end else if (hit) begin
        rd_data_w[g] = rf.wr_data;
        rd_busy_w[g] = 1'b0;
      end
    end
  end

  // Pack per-port results onto the bus.
  always_comb begin
    rf.rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rf.rd_data[i*DATA_W +: DATA_W] = rd_data_w[i];
    end
  end

  assign rf.rd_busy  = rd_busy_w;
  assign rf.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_pipeline_regfile.sv
// Directed bench: one bypassing instance (ia) and one non-bypassing
// instance (ib) driven by the same stimulus.
module tb_pipeline_regfile;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pipeline_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ia ();
  pipeline_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ib ();

  pipeline_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1))
    u_a (.clk(clk), .reset(reset), .rf(ia));
  pipeline_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1))
    u_b (.clk(clk), .reset(reset), .rf(ib));

  assign ib.rd_addr  = ia.rd_addr;
  assign ib.wr_en    = ia.wr_en;
  assign ib.wr_addr  = ia.wr_addr;
  assign ib.wr_data  = ia.wr_data;
  assign ib.iss_en   = ia.iss_en;
  assign ib.iss_addr = ia.iss_addr;
  assign ib.flush    = ia.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ia.wr_en = 1'b0; ia.iss_en = 1'b0; ia.flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    ia.rd_addr = {p1, p0};
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    ia.rd_addr = '0; ia.wr_addr = '0; ia.wr_data = '0; ia.iss_addr = '0;
    idle();

    // Reset: write r7=20 and issue r6 while reset is high
    ia.wr_en = 1'b1; ia.wr_addr = 5'd7; ia.wr_data = 32'd20;
    ia.iss_en = 1'b1; ia.iss_addr = 5'd6;
    set_rd(5'd5, 5'd7);
    #2;
    chk("rst_r5",        ia.rd_data[31:0],  64'd0);
    chk("rst_r7_nobyp",  ia.rd_data[63:32], 64'd0);
    step(); step();
    set_rd(5'd6, 5'd7); #1;
    chk("rst_r6",        ia.rd_data[31:0],  64'd0);
    chk("rst_busy",      ia.rd_busy,        64'd0);
    chk("rst_cnt",       ia.busy_cnt,       64'd0);
    idle();
    @(negedge clk); reset = 1'b0;
    step();
    chk("rst_r7_ignored", ia.rd_data[63:32], 64'd0);
    chk("rst_cnt_after",  ia.busy_cnt,       64'd0);

    // Write/read with and without bypass
    ia.wr_en = 1'b1; ia.wr_addr = 5'd7; ia.wr_data = 32'd20;
    set_rd(5'd0, 5'd7); #1;
    chk("byp_same_cycle",   ia.rd_data[63:32], 64'd20);
    chk("nobyp_same_cycle", ib.rd_data[63:32], 64'd0);
    chk("byp_r0",           ia.rd_data[31:0],  64'd0);
    step(); idle(); #1;
    chk("byp_next",   ia.rd_data[63:32], 64'd20);
    chk("nobyp_next", ib.rd_data[63:32], 64'd20);

    // Zero register ignores writes and issues
    ia.wr_en = 1'b1; ia.wr_addr = 5'd0; ia.wr_data = 32'hDEADBEEF;
    ia.iss_en = 1'b1; ia.iss_addr = 5'd0;
    set_rd(5'd0, 5'd0); #1;
    chk("zero_p0_byp",  ia.rd_data[31:0],  64'd0);
    chk("zero_p1_byp",  ia.rd_data[63:32], 64'd0);
    chk("zero_busy",    ia.rd_busy,        64'd0);
    step(); idle(); #1;
    chk("zero_p0_after", ia.rd_data[31:0], 64'd0);
    chk("zero_busy_aft", ia.rd_busy,       64'd0);
    chk("zero_cnt",      ia.busy_cnt,      64'd0);

    // Scoreboard: issue r4 then r9, writeback r4
    ia.iss_en = 1'b1; ia.iss_addr = 5'd4; step();
    ia.iss_addr = 5'd9; step(); idle();
    set_rd(5'd4, 5'd9); #1;
    chk("sb_cnt2",  ia.busy_cnt, 64'd2);
    chk("sb_busy",  ia.rd_busy,  64'b11);
    ia.wr_en = 1'b1; ia.wr_addr = 5'd4; ia.wr_data = 32'd32; #1;
    chk("sb_wb_data",    ia.rd_data[31:0], 64'd32);
    chk("sb_wb_busy",    ia.rd_busy,       64'b10);
    chk("sb_wb_busy_nb", ib.rd_busy,       64'b11);
    chk("sb_wb_data_nb", ib.rd_data[31:0], 64'd0);
    step(); idle(); #1;
    chk("sb_cnt1",    ia.busy_cnt,      64'd1);
    chk("sb_cnt1_nb", ib.busy_cnt,      64'd1);
    chk("sb_r4_nb",   ib.rd_data[31:0], 64'd32);

    // Simultaneous writeback and issue to r3
    ia.wr_en = 1'b1; ia.wr_addr = 5'd3; ia.wr_data = 32'h33;
    ia.iss_en = 1'b1; ia.iss_addr = 5'd3;
    step(); idle();
    set_rd(5'd3, 5'd9); #1;
    chk("sim_r3_data", ia.rd_data[31:0], 64'h33);
    chk("sim_r3_busy", ia.rd_busy,       64'b11);
    chk("sim_cnt",     ia.busy_cnt,      64'd2);

    // Flush with issue of r8, then reissue r8
    ia.flush = 1'b1; ia.iss_en = 1'b1; ia.iss_addr = 5'd8;
    step(); idle();
    set_rd(5'd8, 5'd9); #1;
    chk("fl_cnt",  ia.busy_cnt, 64'd1);
    chk("fl_busy", ia.rd_busy,  64'b01);
    set_rd(5'd8, 5'd3); #1;
    chk("fl_r3_clear", ia.rd_busy, 64'b01);
    ia.iss_en = 1'b1; ia.iss_addr = 5'd8;
    step(); idle(); #1;
    chk("reissue_cnt", ia.busy_cnt, 64'd1);

    // Async reset mid-run
    ia.wr_en = 1'b1; ia.flush = 1'b1; ia.iss_en = 1'b1;
    ia.wr_addr = 5'd1; ia.wr_data = 32'h11; ia.iss_addr = 5'd10; step();
    ia.flush = 1'b0;
    ia.wr_addr = 5'd2; ia.wr_data = 32'h22; ia.iss_addr = 5'd11; step();
    ia.wr_addr = 5'd3; ia.wr_data = 32'h333; ia.iss_addr = 5'd12; step();
    ia.iss_en = 1'b0;
    ia.wr_addr = 5'd4; ia.wr_data = 32'h44; step();
    ia.wr_addr = 5'd5; ia.wr_data = 32'h55; step();
    idle();
    set_rd(5'd1, 5'd5); #1;
    chk("ar_r1_pre", ia.rd_data[31:0],  64'h11);
    chk("ar_r5_pre", ia.rd_data[63:32], 64'h55);
    chk("ar_cnt_pre", ia.busy_cnt,      64'd3);
    reset = 1'b1; #1;
    chk("ar_r1",  ia.rd_data[31:0],  64'd0);
    chk("ar_r5",  ia.rd_data[63:32], 64'd0);
    chk("ar_cnt", ia.busy_cnt,       64'd0);
    set_rd(5'd10, 5'd2); #1;
    chk("ar_busy", ia.rd_busy,       64'd0);
    chk("ar_r2",   ia.rd_data[63:32], 64'd0);
    @(negedge clk); reset = 1'b0;
    step();
    ia.wr_en = 1'b1; ia.wr_addr = 5'd6; ia.wr_data = 32'h66;
    ia.iss_en = 1'b1; ia.iss_addr = 5'd6;
    step(); idle();
    set_rd(5'd6, 5'd10); #1;
    chk("post_r6",   ib.rd_data[31:0], 64'h66);
    chk("post_busy", ia.rd_busy,       64'b01);
    chk("post_cnt",  ia.busy_cnt,      64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
